aes_req_scheduler: RTL and testbench
====================================

Name: aes_req_scheduler

Overview:
- Shares one iterative AES-128 core and its round controller between NREQ requesters.
- Selects requesters round-robin and latches the winner's plaintext and key.
- Drives the controller's `start` for exactly one full 11-round pass, then captures the ciphertext on `done`.
- Returns the ciphertext, tagged with the requester ID, over a valid/ready response port.
- Sits between the host-side request queues and the AES core plus controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NREQ).
- NRND, 11, cycles `core_start` is held per operation (round 0 load plus rounds 1..10).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  reset, synchronous, active-low; same net as the AES controller reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; pulses for the single cycle a request is accepted.
- req_pt  in  NREQ*128  plaintexts; requester i occupies [128*i+127:128*i].
- req_key  in  NREQ*128  keys; same packing as req_pt.
- core_start  out  1  to controller `start`.
- core_accept  in  1  controller `accept` (high when rndNo==0).
- core_done  in  1  controller `done`.
- core_pt  out  128  registered plaintext to core.
- core_key  out  128  registered key to core.
- core_ct  in  128  ciphertext from core, valid while core_done is high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester index of the response.
- rsp_ct  out  128  ciphertext.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set when core_done is missing at the expected cycle.

Behaviour:
- Reset (rstn==0 at a clock edge) forces:
  - state = IDLE, rr_ptr = 0, cnt = 0;
  - req_ready = 0, core_start = 0, rsp_valid = 0, busy = 0, err = 0;
  - core_pt, core_key, rsp_ct and rsp_id all zero.
  - Reset mid-operation abandons the operation and issues no response. The controller resets on the same edge.
- FSM states: IDLE, RUN, CHK, RESP.
- IDLE:
  - If |req_valid and core_accept, grant the first valid requester found searching upward from rr_ptr with wrap-around.
  - Grant actions in that same cycle:
    - req_ready[g] = 1 (combinational from the registered state and req_valid);
    - at the clock edge, latch core_pt/core_key from requester g and set rsp_id = g;
    - set rr_ptr = (g+1) mod NREQ, cnt = 0; next state RUN.
  - If core_accept is 0, grant nothing.
- RUN:
  - core_start = 1; cnt increments each cycle.
  - After NRND cycles (cnt == NRND-1) go to CHK.
  - core_pt and core_key stay stable throughout.
- CHK:
  - core_start = 0.
  - If core_done == 1, capture rsp_ct = core_ct and go to RESP.
  - Otherwise set err = 1 and go to IDLE with no response.
- RESP:
  - rsp_valid = 1; rsp_ct and rsp_id are held.
  - When rsp_ready == 1, deassert at the edge and go to IDLE.
  - No new grant while in RESP (single response buffer).
- core_start must never be high outside RUN. Holding it one extra cycle would start a spurious pass in the controller.
- Latency:
  - Grant cycle T0; RUN T1..T11; CHK T12; rsp_valid first high at T13.
  - With rsp_ready held high, the next grant is earliest at T14. Throughput is 1 operation per 14 cycles.
- Simultaneous events:
  - Requests arriving during RUN/CHK/RESP are held by the requesters (valid must stay high until ready).
  - A requester dropping valid before grant is legal and simply not served.
- Fairness: with all NREQ valid continuously, grants go 0,1,2,...,NREQ-1,0,...; no requester waits more than NREQ-1 operations.
- busy = (state != IDLE).
- err clears only on reset.

Test Plan:
- Single request, FIPS-197 vector on requester 2: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, rsp_ready=1 -> req_ready=0100 at T0, core_start high exactly 11 cycles, rsp_valid at T13 with rsp_id=2 and rsp_ct=69c4e0d86a7b0430d8cdb78070b4c55a.
- All 4 requesters valid continuously for 8 operations -> grant order 0,1,2,3,0,1,2,3; each rsp_id matches its grant; grants spaced 14 cycles.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_ct and rsp_id stable, no req_ready pulses, core_start=0; release -> the next grant follows the cycle after the handshake.
- Reset asserted at T5 of RUN -> next cycle all outputs zero, no rsp_valid; a fresh request after reset completes correctly with rr_ptr restarted at 0.
- Fault injection: bench model forces core_done=0 at CHK -> err=1 sticky, no rsp_valid, FSM back in IDLE and the next request still served.
- Requester 1 drops req_valid while requester 3 is being served -> the next grant goes to the next valid requester after 3 in round-robin order, never to 1.

Source files
------------

// File: rtl/aes_req_scheduler_if.sv
// Host-side request/response bundle for aes_req_scheduler.
// Requests and responses both use valid/ready: a transfer happens on a rising clk edge where valid
// and ready are both high; a valid, once raised, holds its payload until that edge.
interface aes_req_scheduler_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_pt;
  logic [NREQ*128-1:0] req_key;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [127:0]        rsp_ct;

  modport master (
    output req_valid, req_pt, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_ct
  );

  modport slave (
    input  req_valid, req_pt, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_ct
  );
endinterface

// File: rtl/aes_req_scheduler.sv
// Round-robin arbiter that time-shares one iterative AES-128 core among NREQ requesters,
// running one full round pass per grant and returning the tagged ciphertext.
module aes_req_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int NRND = 11
) (
  input  logic                clk,
  input  logic                rstn,
  aes_req_scheduler_if.slave  bus,
  output logic                core_start,
  input  logic                core_accept,
  input  logic                core_done,
  output logic [127:0]        core_pt,
  output logic [127:0]        core_key,
  input  logic [127:0]        core_ct,
  output logic                busy,
  output logic                err,
  output logic [1:0]          state_dbg
);

  localparam int CNT_W = $clog2(NRND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CHK  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [127:0]    rsp_ct_q;

  logic            grant;
  logic            found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] next_ptr;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    grant         = (state == IDLE) && core_accept && found;
    bus.req_ready = '0;
    if (grant) bus.req_ready[grant_idx] = 1'b1;
  end

  assign next_ptr = (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_ct    = rsp_ct_q;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_ct_q    <= '0;
      core_pt     <= '0;
      core_key    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            core_pt    <= bus.req_pt[128*int'(grant_idx) +: 128];
            core_key   <= bus.req_key[128*int'(grant_idx) +: 128];
            rsp_id_q   <= grant_idx;
            rr_ptr     <= next_ptr;
            cnt        <= '0;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          // start must drop exactly after NRND cycles or the controller begins another pass
          if (cnt == CNT_W'(NRND-1)) begin
            core_start <= 1'b0;
            state      <= CHK;
          end
        end
        CHK: begin
          if (core_done) begin
            rsp_ct_q    <= core_ct;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          core_start  <= 1'b0;
          rsp_valid_q <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler with a behavioural AES controller stand-in.
module tb_aes_req_scheduler;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] SALT     = 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  aes_req_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  logic         core_start, core_accept, core_done, busy, err;
  logic [127:0] core_pt, core_key, core_ct;
  logic [1:0]   state_dbg;

  aes_req_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .NRND(11)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .core_start(core_start), .core_accept(core_accept), .core_done(core_done),
    .core_pt(core_pt), .core_key(core_key), .core_ct(core_ct),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- controller model ----------------
  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ key ^ SALT;
  endfunction

  logic [3:0] run_cnt;
  logic       done_q;
  logic       force_no_done;
  logic       accept_low;

  always @(posedge clk) begin
    if (!rstn) begin
      run_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= core_start && (run_cnt == 4'd10);
      run_cnt <= core_start ? run_cnt + 4'd1 : 4'd0;
    end
  end

  assign core_done   = done_q & ~force_no_done;
  assign core_accept = ~core_start & ~done_q & ~accept_low;
  assign core_ct     = done_q ? model_ct(core_pt, core_key) : ~model_ct(core_pt, core_key);

  // ---------------- bookkeeping ----------------
  int chk_total = 0;
  int chk_pass  = 0;
  logic [ID_W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    bus.req_valid = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [127:0] pt, input logic [127:0] key);
    bus.req_pt[128*i +: 128]  = pt;
    bus.req_key[128*i +: 128] = key;
  endtask

  task automatic wait_rsp(input int bound, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      if (bus.rsp_valid) ok = 1'b1;
      else step();
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    step(); step(); step();
    chk_total++;
    if ({core_start, busy, err, bus.rsp_valid} !== 4'b0000)
      $display("FAIL reset_ctrl: start/busy/err/rsp_valid=%b expected 0000", {core_start, busy, err, bus.rsp_valid});
    else chk_pass++;
    chk_total++;
    if ({core_pt, core_key, bus.rsp_ct} !== '0 || bus.rsp_id !== '0 || bus.req_ready !== '0 || state_dbg !== 2'd0)
      $display("FAIL reset_data: pt=%h key=%h ct=%h id=%0d ready=%b state=%0d expected all 0",
               core_pt, core_key, bus.rsp_ct, bus.rsp_id, bus.req_ready, state_dbg);
    else chk_pass++;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int start_cnt, rsp_at;
    logic [ID_W-1:0] id_seen;
    logic [127:0] ct_seen, pt_seen;
    start_cnt = 0; rsp_at = 0; id_seen = '0; ct_seen = '0; pt_seen = '0;
    set_req(2, FIPS_PT, FIPS_KEY);
    bus.rsp_ready = 1'b1;
    accept_low = 1'b1;
    bus.req_valid = 4'b0100;
    step(); step();
    chk_total++;
    if (bus.req_ready !== 4'b0000 || busy !== 1'b0)
      $display("FAIL no_accept_no_grant: ready=%b busy=%b expected 0000/0", bus.req_ready, busy);
    else chk_pass++;
    accept_low = 1'b0;
    #1;
    chk_total++;
    if (bus.req_ready !== 4'b0100) $display("FAIL single_grant: req_ready=%b expected 0100", bus.req_ready);
    else chk_pass++;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) begin
        bus.req_valid = '0;
        pt_seen = core_pt;
      end
      if (core_start) start_cnt++;
      if (bus.rsp_valid && rsp_at == 0) begin
        rsp_at = c; id_seen = bus.rsp_id; ct_seen = bus.rsp_ct;
      end
    end
    chk_total++;
    if (start_cnt != 11) $display("FAIL single_start_len: core_start cycles=%0d expected 11", start_cnt);
    else chk_pass++;
    chk_total++;
    if (rsp_at != 13) $display("FAIL single_latency: rsp_valid at T%0d expected T13", rsp_at);
    else chk_pass++;
    chk_total++;
    if (id_seen !== 2'd2 || ct_seen !== FIPS_CT)
      $display("FAIL single_rsp: id=%0d ct=%h expected 2 %h", id_seen, ct_seen, FIPS_CT);
    else chk_pass++;
    chk_total++;
    if (pt_seen !== FIPS_PT || busy !== 1'b0)
      $display("FAIL single_pt_idle: core_pt=%h busy=%b expected %h 0", pt_seen, busy, FIPS_PT);
    else chk_pass++;
  endtask

  task automatic test_back_to_back();
    int grants[8];
    int gt[8];
    int n_grant, n_rsp, bad_id, bad_sp;
    logic [ID_W-1:0] exp_id;
    n_grant = 0; n_rsp = 0; bad_id = 0; bad_sp = 0;
    reset_dut();
    for (int i = 0; i < NREQ; i++)
      set_req(i, {32'(i), 96'h0123_4567_89ab_cdef_0000_1111} ^ 128'hffff, {4{32'h1000_0000 + 32'(i)}});
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    for (int cyc = 0; cyc < 130 && n_rsp < 8; cyc++) begin
      if (cyc > 0) step();
      if (bus.req_ready !== '0 && n_grant < 8) begin
        grants[n_grant] = onehot_idx(bus.req_ready);
        gt[n_grant] = cyc;
        exp_q.push_back(ID_W'(grants[n_grant]));
        n_grant++;
      end
      if (bus.rsp_valid) begin
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
        if (bus.rsp_id !== exp_id ||
            bus.rsp_ct !== model_ct(bus.req_pt[128*int'(exp_id) +: 128], bus.req_key[128*int'(exp_id) +: 128]))
          bad_id++;
        n_rsp++;
      end
    end
    bus.req_valid = '0;
    chk_total++;
    if (n_grant != 8 || n_rsp != 8) $display("FAIL b2b_count: grants=%0d rsps=%0d expected 8 8", n_grant, n_rsp);
    else chk_pass++;
    for (int i = 0; i < n_grant; i++) begin
      chk_total++;
      if (grants[i] != i % NREQ) $display("FAIL b2b_order: grant %0d went to %0d expected %0d", i, grants[i], i % NREQ);
      else chk_pass++;
      if (i > 0 && gt[i] - gt[i-1] != 14) bad_sp++;
    end
    chk_total++;
    if (bad_sp != 0) $display("FAIL b2b_spacing: %0d gaps differ from 14 cycles expected 0", bad_sp);
    else chk_pass++;
    chk_total++;
    if (bad_id != 0 || exp_q.size() != 0)
      $display("FAIL b2b_rsp: bad responses=%0d leftover=%0d expected 0 0", bad_id, exp_q.size());
    else chk_pass++;
    step();
  endtask

  task automatic test_backpressure();
    logic ok;
    int bad_hold, bad_ready, bad_start;
    logic [127:0] exp_ct;
    bad_hold = 0; bad_ready = 0; bad_start = 0;
    reset_dut();
    set_req(0, 128'hdead_beef, 128'h0bad_cafe);
    set_req(1, 128'h1111_2222, 128'h3333_4444);
    exp_ct = model_ct(128'hdead_beef, 128'h0bad_cafe);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    chk_total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL bp_grant: req_ready=%b expected 0001", bus.req_ready);
    else chk_pass++;
    step();
    bus.req_valid = 4'b0010;
    wait_rsp(20, ok);
    chk_total++;
    if (!ok) $display("FAIL bp_rsp_timeout: rsp_valid=%b expected 1 within 20 cycles", bus.rsp_valid);
    else chk_pass++;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_ct !== exp_ct) bad_hold++;
      if (bus.req_ready !== '0) bad_ready++;
      if (core_start !== 1'b0) bad_start++;
    end
    chk_total++;
    if (bad_hold != 0) $display("FAIL bp_hold: %0d cycles with changed response expected 0", bad_hold);
    else chk_pass++;
    chk_total++;
    if (bad_ready != 0 || bad_start != 0)
      $display("FAIL bp_quiet: ready pulses=%0d start cycles=%0d expected 0 0", bad_ready, bad_start);
    else chk_pass++;
    bus.rsp_ready = 1'b1;
    step();
    chk_total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010)
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 0 0010", bus.rsp_valid, bus.req_ready);
    else chk_pass++;
    step();
    bus.req_valid = '0;
    wait_rsp(20, ok);
    chk_total++;
    if (!ok || bus.rsp_id !== 2'd1) $display("FAIL bp_next_rsp: ok=%b id=%0d expected 1 1", ok, bus.rsp_id);
    else chk_pass++;
    step();
  endtask

  task automatic test_fault();
    logic ok;
    int rsp_seen;
    rsp_seen = 0;
    reset_dut();
    set_req(0, 128'h0a0a, 128'hb0b0);
    set_req(1, 128'h7777, 128'h8888);
    bus.rsp_ready = 1'b1;
    force_no_done = 1'b1;
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    for (int c = 2; c <= 13; c++) begin
      step();
      if (bus.rsp_valid) rsp_seen++;
    end
    chk_total++;
    if (err !== 1'b1 || rsp_seen != 0)
      $display("FAIL fault_err: err=%b rsp cycles=%0d expected 1 0", err, rsp_seen);
    else chk_pass++;
    chk_total++;
    if (busy !== 1'b0 || state_dbg !== 2'd0)
      $display("FAIL fault_idle: busy=%b state=%0d expected 0 0", busy, state_dbg);
    else chk_pass++;
    force_no_done = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    chk_total++;
    if (bus.req_ready !== 4'b0010) $display("FAIL fault_regrant: req_ready=%b expected 0010", bus.req_ready);
    else chk_pass++;
    step();
    bus.req_valid = '0;
    wait_rsp(20, ok);
    chk_total++;
    if (!ok || bus.rsp_id !== 2'd1 || bus.rsp_ct !== model_ct(128'h7777, 128'h8888) || err !== 1'b1)
      $display("FAIL fault_recover: ok=%b id=%0d ct=%h err=%b expected 1 1 %h 1",
               ok, bus.rsp_id, bus.rsp_ct, err, model_ct(128'h7777, 128'h8888));
    else chk_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    logic ok;
    int rsp_seen;
    rsp_seen = 0;
    set_req(2, 128'h2222, 128'h2323);
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    step(); step(); step(); step();
    rstn = 1'b0;
    step();
    chk_total++;
    if ({core_start, busy, err, bus.rsp_valid} !== 4'b0000 || bus.req_ready !== '0)
      $display("FAIL midreset_ctrl: start/busy/err/rsp_valid=%b ready=%b expected 0000 0000",
               {core_start, busy, err, bus.rsp_valid}, bus.req_ready);
    else chk_pass++;
    chk_total++;
    if ({core_pt, core_key, bus.rsp_ct} !== '0 || bus.rsp_id !== '0 || state_dbg !== 2'd0)
      $display("FAIL midreset_data: pt=%h key=%h ct=%h id=%0d state=%0d expected all 0",
               core_pt, core_key, bus.rsp_ct, bus.rsp_id, state_dbg);
    else chk_pass++;
    rstn = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (bus.rsp_valid || core_start) rsp_seen++;
    end
    chk_total++;
    if (rsp_seen != 0) $display("FAIL midreset_quiet: active cycles=%0d expected 0", rsp_seen);
    else chk_pass++;
    set_req(1, 128'h1212, 128'h3434);
    set_req(3, 128'h5656, 128'h7878);
    bus.req_valid = 4'b1010;
    #1;
    chk_total++;
    if (bus.req_ready !== 4'b0010) $display("FAIL midreset_rrptr: req_ready=%b expected 0010", bus.req_ready);
    else chk_pass++;
    step();
    bus.req_valid = '0;
    wait_rsp(20, ok);
    chk_total++;
    if (!ok || bus.rsp_id !== 2'd1 || bus.rsp_ct !== model_ct(128'h1212, 128'h3434))
      $display("FAIL midreset_rsp: ok=%b id=%0d ct=%h expected 1 1 %h", ok, bus.rsp_id, bus.rsp_ct, model_ct(128'h1212, 128'h3434));
    else chk_pass++;
    step();
  endtask

  task automatic test_drop();
    logic ok, got;
    int g, first_id, bad1;
    got = 1'b0; g = -1; first_id = -1; bad1 = 0;
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_req(i, 128'hc0de_0000 + 128'(i), 128'h0000_f00d + 128'(i));
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    chk_total++;
    if (bus.req_ready !== 4'b1000) $display("FAIL drop_first: req_ready=%b expected 1000", bus.req_ready);
    else chk_pass++;
    step();
    bus.req_valid = 4'b0110;
    step(); step(); step();
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 30 && !got; c++) begin
      step();
      if (bus.rsp_valid) first_id = int'(bus.rsp_id);
      if (bus.req_ready[1]) bad1++;
      if (bus.req_ready !== '0) begin got = 1'b1; g = onehot_idx(bus.req_ready); end
    end
    chk_total++;
    if (first_id != 3) $display("FAIL drop_served3: rsp_id=%0d expected 3", first_id);
    else chk_pass++;
    chk_total++;
    if (!got || g != 2 || bad1 != 0) $display("FAIL drop_next: got=%b grant=%0d r1 grants=%0d expected 1 2 0", got, g, bad1);
    else chk_pass++;
    step();
    bus.req_valid = '0;
    wait_rsp(20, ok);
    chk_total++;
    if (!ok || bus.rsp_id !== 2'd2) $display("FAIL drop_rsp: ok=%b id=%0d expected 1 2", ok, bus.rsp_id);
    else chk_pass++;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rstn = 1'b0;
    force_no_done = 1'b0;
    accept_low = 1'b0;
    bus.req_valid = '0;
    bus.req_pt = '0;
    bus.req_key = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fault();
    test_reset_mid();
    test_drop();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", chk_pass, chk_total);
    $fatal(1);
  end

endmodule
